// File: rtl/softmax_pkg.sv
// Shared types and helpers for the approximate-softmax datapath.
package softmax_pkg;

    localparam int EXP_W   = 21;
    localparam int MANT_W  = 16;
    localparam int POS_W   = 5;
    localparam int PROB_W  = 16;
    localparam int QUO_W   = 17;
    localparam int POS_MAX = 16;
    localparam int VAL_W   = 32;

    typedef enum logic [1:0] {
        ACCUM,
        DIV,
        OUT
    } norm_state_t;

    // Exponent word to fixed point, value scaled by 2^16.
    function automatic logic [VAL_W-1:0] unpack_exp(
        input logic [EXP_W-1:0] w
    );
        logic [POS_W-1:0] e;
        e = w[EXP_W-1 -: POS_W];
        if (e > POS_W'(POS_MAX)) begin
            e = POS_W'(POS_MAX);
        end
        return VAL_W'(w[MANT_W-1:0]) << e;
    endfunction

    function automatic logic [PROB_W-1:0] sat_prob(
        input logic [QUO_W-1:0] q
    );
        return q[QUO_W-1] ? '1 : q[PROB_W-1:0];
    endfunction

endpackage

// File: rtl/softmax_div.sv
// Bit-serial restoring divider, one quotient bit per cycle, MSB first.
// The first bit is resolved on the start edge; zero divisor yields zero.
module softmax_div #(
    parameter int DIVIDEND_W = 48,
    parameter int DIVISOR_W  = 35,
    parameter int QUO_W      = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [QUO_W-1:0]      quotient
);

    localparam int CNT_W = $clog2(QUO_W);

    logic [DIVISOR_W-1:0] rem_q;
    logic [DIVISOR_W-1:0] div_q;
    logic [DIVISOR_W-1:0] src_rem;
    logic [DIVISOR_W-1:0] src_div;
    logic [DIVISOR_W-1:0] rem_d;
    logic [QUO_W-1:0]     lo_q;
    logic [QUO_W-1:0]     src_lo;
    logic [QUO_W-1:0]     q_q;
    logic [QUO_W-1:0]     q_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 zero_q;
    logic [DIVISOR_W:0]   trial;
    logic                 ge;

    always_comb begin
        src_rem = start ? DIVISOR_W'(dividend >> QUO_W) : rem_q;
        src_div = start ? divisor : div_q;
        src_lo  = start ? dividend[QUO_W-1:0] : lo_q;
        trial   = {src_rem, src_lo[QUO_W-1]};
        ge      = trial >= {1'b0, src_div};
        rem_d   = ge ? DIVISOR_W'(trial - {1'b0, src_div})
                     : trial[DIVISOR_W-1:0];
        q_d     = start ? QUO_W'(ge) : {q_q[QUO_W-2:0], ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            div_q  <= '0;
            lo_q   <= '0;
            q_q    <= '0;
            cnt_q  <= '0;
            zero_q <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q  <= rem_d;
                div_q  <= divisor;
                lo_q   <= src_lo << 1;
                q_q    <= q_d;
                zero_q <= (divisor == '0);
                cnt_q  <= CNT_W'(QUO_W - 1);
                busy   <= 1'b1;
            end else if (busy) begin
                rem_q <= rem_d;
                lo_q  <= src_lo << 1;
                q_q   <= q_d;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = zero_q ? '0 : q_q;

endmodule

// File: rtl/softmax_norm.sv
// Softmax normalisation: buffers N exponent words, sums them and
// emits each word divided by the sum as a Q0.16 probability.
module softmax_norm
    import softmax_pkg::*;
#(
    parameter int N     = 8,
    parameter int SUM_W = 32 + $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROB_W-1:0] out_prob,
    output logic              out_last
);

    localparam int IDX_W = $clog2(N);
    localparam int NUM_W = VAL_W + PROB_W;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    norm_state_t      state_q;
    norm_state_t      state_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [IDX_W-1:0] div_idx;
    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] sum_d;
    logic [SUM_W-1:0] sum_add;
    logic [SUM_W-1:0] div_den;
    logic [VAL_W-1:0] in_val;
    logic [VAL_W-1:0] buf_mem [N];
    logic [NUM_W-1:0] div_num;
    logic [QUO_W-1:0] div_quo;
    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic             load_out;
    logic             idx_last;
    logic             in_hs;

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == OUT);
    assign in_hs     = in_valid && in_ready;
    assign idx_last  = (idx_q == IDX_LAST);
    assign in_val    = unpack_exp(in_exp);
    assign sum_add   = sum_q + SUM_W'(in_val);
    assign div_num   = {buf_mem[div_idx], {PROB_W{1'b0}}};

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        div_start = 1'b0;
        div_idx   = idx_q;
        div_den   = sum_q;
        load_out  = 1'b0;
        unique case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    sum_d = sum_add;
                    if (idx_last) begin
                        // Final sum is not registered yet; feed it directly.
                        state_d   = DIV;
                        idx_d     = '0;
                        div_start = 1'b1;
                        div_idx   = '0;
                        div_den   = sum_add;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DIV: begin
                if (div_done && !div_busy) begin
                    state_d  = OUT;
                    load_out = 1'b1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    if (idx_last) begin
                        state_d = ACCUM;
                        idx_d   = '0;
                        sum_d   = '0;
                    end else begin
                        state_d   = DIV;
                        idx_d     = idx_q + 1'b1;
                        div_idx   = idx_q + 1'b1;
                        div_start = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ACCUM;
            idx_q    <= '0;
            sum_q    <= '0;
            out_prob <= '0;
            out_last <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            if (load_out) begin
                out_prob <= sat_prob(div_quo);
                out_last <= idx_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_hs) begin
            buf_mem[idx_q] <= in_val;
        end
    end

    softmax_div #(
        .DIVIDEND_W (NUM_W),
        .DIVISOR_W  (SUM_W),
        .QUO_W      (QUO_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_num),
        .divisor  (div_den),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

endmodule

// File: tb/tb_softmax_norm.sv
// Directed bench for softmax_norm with an expected-result queue.
module tb_softmax_norm;

    typedef struct {
        logic [15:0] prob;
        logic        last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       in_valid;
    logic [1:0]       in_ready;
    logic [1:0][20:0] in_exp;
    logic [1:0]       out_valid;
    logic [1:0]       out_ready;
    logic [1:0][15:0] out_prob;
    logic [1:0]       out_last;

    exp_t        sb[$];
    logic [20:0] vec [4];
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    softmax_norm #(.N(4)) u4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_exp    (in_exp[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_prob  (out_prob[0]),
        .out_last  (out_last[0])
    );

    softmax_norm #(.N(2)) u2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_exp    (in_exp[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_prob  (out_prob[1]),
        .out_last  (out_last[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference value of an exponent word, scaled by 2^16.
    function automatic logic [63:0] mval(input logic [20:0] w);
        int e;
        e = int'(w[20:16]);
        if (e > 16) e = 16;
        return 64'(w[15:0]) * (64'd1 << e);
    endfunction

    task automatic run_vec(input int k, input int n, input int ncol,
                           input int stall_at, input bit chk_lat,
                           input string tag);
        logic [63:0] sum;
        logic [63:0] q;
        exp_t        e;
        int          cyc;
        sb.delete();
        sum = 0;
        for (int i = 0; i < n; i++) sum += mval(vec[i]);
        for (int i = 0; i < n; i++) begin
            q = (sum == 0) ? 64'd0 : (mval(vec[i]) * 64'd65536) / sum;
            e.prob = (q > 64'hFFFF) ? 16'hFFFF : q[15:0];
            e.last = (i == n - 1);
            sb.push_back(e);
        end
        out_ready[k] = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_valid[k] = 1'b1;
            in_exp[k]   = vec[i];
            chk({tag, "_in_ready"}, 64'(in_ready[k]), 64'd1);
            @(posedge clk);
            #1;
        end
        in_valid[k] = 1'b0;
        for (int j = 0; j < ncol; j++) begin
            if (j == stall_at) out_ready[k] = 1'b0;
            cyc = 0;
            while (!out_valid[k] && cyc < 40) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            chk({tag, "_valid"}, 64'(out_valid[k]), 64'd1);
            if (!out_valid[k]) return;
            if (chk_lat) chk({tag, "_lat"}, 64'(cyc), 64'd17);
            e = sb.pop_front();
            chk({tag, "_prob"}, 64'(out_prob[k]), 64'(e.prob));
            chk({tag, "_last"}, 64'(out_last[k]), 64'(e.last));
            if (j == stall_at) begin
                for (int s = 0; s < 5; s++) begin
                    @(posedge clk);
                    #1;
                    chk({tag, "_hold"},
                        {out_valid[k], in_ready[k], out_last[k], out_prob[k]},
                        {1'b1, 1'b0, e.last, e.prob});
                end
                out_ready[k] = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (ncol == n) begin
            chk({tag, "_idle"}, {in_ready[k], out_valid[k]}, 64'b10);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        in_exp    = '0;
        out_ready = '0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_in_ready", 64'(in_ready[k]), 64'd1);
            chk("rst_out_valid", 64'(out_valid[k]), 64'd0);
            chk("rst_out_prob", 64'(out_prob[k]), 64'd0);
            chk("rst_out_last", 64'(out_last[k]), 64'd0);
        end
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) vec[i] = {5'd1, 16'h8000};
        run_vec(0, 4, 4, -1, 1'b1, "ones");

        vec[0] = {5'd2, 16'hC000};
        vec[1] = {5'd1, 16'h8000};
        run_vec(1, 2, 2, -1, 1'b1, "n2");

        vec[0] = {5'd1, 16'h8000};
        vec[1] = {5'd5, 16'h0000};
        vec[2] = {5'd0, 16'h0000};
        vec[3] = {5'd9, 16'h0000};
        run_vec(0, 4, 4, -1, 1'b1, "sat");

        for (int i = 0; i < 4; i++) vec[i] = {5'd3, 16'h0000};
        run_vec(0, 4, 4, -1, 1'b1, "zero");

        vec[0] = {5'd20, 16'h0001};
        vec[1] = {5'd2, 16'h8000};
        vec[2] = {5'd0, 16'h8000};
        vec[3] = {5'd0, 16'h8000};
        run_vec(0, 4, 4, 1, 1'b1, "bp");

        vec[0] = {5'd2, 16'h8000};
        vec[1] = {5'd1, 16'h8000};
        vec[2] = {5'd1, 16'h8000};
        vec[3] = {5'd3, 16'h8000};
        run_vec(0, 4, 2, -1, 1'b1, "old");
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_div", {out_valid[0], in_ready[0]}, 64'b00);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid[0]), 64'd0);
        chk("mid_rst_ready", 64'(in_ready[0]), 64'd1);
        chk("mid_rst_prob", 64'(out_prob[0]), 64'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_hold", {out_valid[0], in_ready[0]}, 64'b01);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) vec[i] = {5'd1, 16'h8000};
        run_vec(0, 4, 4, -1, 1'b1, "fresh");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
